// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one 8N1 UART transmitter among NREQ byte-stream requesters.
// A grant is held for a whole packet (up to req_last) and revoked if the owner stalls too long.
module uart_tx_arbiter #(
    parameter int unsigned NREQ    = 4,
    parameter int unsigned IDW     = 2,
    parameter int unsigned TIMEOUT = 1048575,
    parameter int unsigned TOW     = 20
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NREQ-1:0]   req_valid_i,
    input  logic [8*NREQ-1:0] req_data_i,
    input  logic [NREQ-1:0]   req_last_i,
    output logic [NREQ-1:0]   req_ready_o,
    output logic              grant_valid_o,
    output logic [IDW-1:0]    grant_id_o,
    output logic              tx_start_o,
    output logic [7:0]        tx_data_o,
    input  logic              tx_busy_i,
    output logic              timeout_err_o
);

    typedef enum logic [2:0] {StIdle, StHold, StStart, StWaitHi, StWaitLo} state_e;

    state_e         state_q, state_d;
    logic [IDW-1:0] ptr_q, ptr_d;
    logic [IDW-1:0] gid_q, gid_d;
    logic           gvalid_q, gvalid_d;
    logic           start_q, start_d;
    logic           last_q, last_d;
    logic           terr_q, terr_d;
    logic [7:0]     data_q, data_d;
    logic [TOW-1:0] to_cnt_q, to_cnt_d;
    logic [1:0]     retry_q, retry_d;

    logic           arb_found;
    logic [IDW-1:0] arb_pick;
    int unsigned    arb_idx;
    logic [IDW-1:0] ptr_next;
    logic           handshake;

    // First valid requester at or after ptr, wrapping modulo NREQ.
    always_comb begin
        arb_found = 1'b0;
        arb_pick  = '0;
        arb_idx   = 0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            arb_idx = (32'(ptr_q) + k) % NREQ;
            if (!arb_found && req_valid_i[arb_idx]) begin
                arb_found = 1'b1;
                arb_pick  = IDW'(arb_idx);
            end
        end
    end

    assign ptr_next  = IDW'((32'(gid_q) + 1) % NREQ);
    assign handshake = (state_q == StHold) && !tx_busy_i && req_valid_i[gid_q];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= StIdle;
            ptr_q    <= '0;
            gid_q    <= '0;
            gvalid_q <= 1'b0;
            start_q  <= 1'b0;
            last_q   <= 1'b0;
            terr_q   <= 1'b0;
            data_q   <= 8'h00;
            to_cnt_q <= '0;
            retry_q  <= '0;
        end else begin
            state_q  <= state_d;
            ptr_q    <= ptr_d;
            gid_q    <= gid_d;
            gvalid_q <= gvalid_d;
            start_q  <= start_d;
            last_q   <= last_d;
            terr_q   <= terr_d;
            data_q   <= data_d;
            to_cnt_q <= to_cnt_d;
            retry_q  <= retry_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        ptr_d    = ptr_q;
        gid_d    = gid_q;
        gvalid_d = gvalid_q;
        start_d  = 1'b0;
        last_d   = last_q;
        terr_d   = 1'b0;
        data_d   = data_q;
        to_cnt_d = to_cnt_q;
        retry_d  = retry_q;
        case (state_q)
            StIdle: begin
                if (arb_found) begin
                    gid_d    = arb_pick;
                    gvalid_d = 1'b1;
                    to_cnt_d = '0;
                    state_d  = StHold;
                end
            end
            StHold: begin
                // A handshake in the expiry cycle takes priority over the timeout.
                if (handshake) begin
                    data_d   = req_data_i[8*gid_q +: 8];
                    last_d   = req_last_i[gid_q];
                    start_d  = 1'b1;
                    to_cnt_d = '0;
                    state_d  = StStart;
                end else if (to_cnt_q == TOW'(TIMEOUT - 1)) begin
                    terr_d   = 1'b1;
                    gvalid_d = 1'b0;
                    ptr_d    = ptr_next;
                    state_d  = StIdle;
                end else begin
                    to_cnt_d = to_cnt_q + 1'b1;
                end
            end
            StStart: begin
                retry_d = '0;
                state_d = StWaitHi;
            end
            StWaitHi: begin
                // Busy never rose: the start was lost, so pulse again with the same byte.
                if (tx_busy_i) begin
                    state_d = StWaitLo;
                end else if (retry_q == 2'd3) begin
                    start_d = 1'b1;
                    state_d = StStart;
                end else begin
                    retry_d = retry_q + 2'd1;
                end
            end
            StWaitLo: begin
                if (!tx_busy_i) begin
                    if (last_q) begin
                        gvalid_d = 1'b0;
                        ptr_d    = ptr_next;
                        state_d  = StIdle;
                    end else begin
                        to_cnt_d = '0;
                        state_d  = StHold;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        req_ready_o = '0;
        if (state_q == StHold && !tx_busy_i) begin
            req_ready_o[gid_q] = 1'b1;
        end
    end

    assign grant_valid_o = gvalid_q;
    assign grant_id_o    = gid_q;
    assign tx_start_o    = start_q;
    assign tx_data_o     = data_q;
    assign timeout_err_o = terr_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: queued requesters plus a busy-counting transmitter model
// that logs every start pulse, accepted byte and busy fall with its cycle number.
module tb_uart_tx_arbiter;

    localparam int BUSY_LEN = 10;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  req_valid;
    logic [31:0] req_data;
    logic [3:0]  req_last;
    logic [3:0]  req_ready;
    logic        grant_valid;
    logic [1:0]  grant_id;
    logic        tx_start;
    logic [7:0]  tx_data;
    logic        tx_busy;
    logic        timeout_err;

    int n_assert = 0;
    int n_fail   = 0;

    uart_tx_arbiter #(
        .NREQ(4),
        .IDW(2),
        .TIMEOUT(50),
        .TOW(6)
    ) dut (
        .clk(clk),
        .rst(rst),
        .req_valid_i(req_valid),
        .req_data_i(req_data),
        .req_last_i(req_last),
        .req_ready_o(req_ready),
        .grant_valid_o(grant_valid),
        .grant_id_o(grant_id),
        .tx_start_o(tx_start),
        .tx_data_o(tx_data),
        .tx_busy_i(tx_busy),
        .timeout_err_o(timeout_err)
    );

    always #5 clk = ~clk;

    // Transmitter model: accepts a start only when idle, optionally drops one start on request.
    int         cyc = 0;
    int         busy_cnt = 0;
    int         n_pulse = 0, n_acc = 0, n_fall = 0, n_early = 0;
    int         drop_req = 0, drop_ack = 0;
    logic [7:0] pulse_data [64];
    int         pulse_cyc  [64];
    logic [7:0] acc_data   [64];
    int         acc_cyc    [64];
    int         fall_cyc   [64];

    assign tx_busy = (busy_cnt != 0);

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (busy_cnt != 0) begin
            busy_cnt <= busy_cnt - 1;
            if (busy_cnt == 1) begin
                fall_cyc[n_fall % 64] <= cyc + 1;
                n_fall <= n_fall + 1;
            end
        end
        if (tx_start) begin
            pulse_data[n_pulse % 64] <= tx_data;
            pulse_cyc[n_pulse % 64]  <= cyc;
            n_pulse <= n_pulse + 1;
            if (tx_busy) begin
                n_early <= n_early + 1;
            end else if (drop_ack != drop_req) begin
                drop_ack <= drop_req;
            end else begin
                busy_cnt <= BUSY_LEN;
                acc_data[n_acc % 64] <= tx_data;
                acc_cyc[n_acc % 64]  <= cyc;
                n_acc <= n_acc + 1;
            end
        end
    end

    // Requester queues: {last, byte}
    logic [8:0] rq_mem [4][8];
    int         rq_head [4];
    int         rq_tail [4];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic push(input int id, input logic [7:0] b, input logic last);
        rq_mem[id][rq_tail[id] % 8] = {last, b};
        rq_tail[id]++;
    endtask

    task automatic clear_queues();
        for (int i = 0; i < 4; i++) begin
            rq_head[i] = 0;
            rq_tail[i] = 0;
        end
    endtask

    task automatic drive();
        for (int i = 0; i < 4; i++) begin
            if (rq_head[i] < rq_tail[i]) begin
                req_valid[i]       = 1'b1;
                req_data[8*i +: 8] = rq_mem[i][rq_head[i] % 8][7:0];
                req_last[i]        = rq_mem[i][rq_head[i] % 8][8];
            end else begin
                req_valid[i]       = 1'b0;
                req_data[8*i +: 8] = 8'hEE;
                req_last[i]        = 1'b1;
            end
        end
    endtask

    function automatic bit queues_empty();
        bit e = 1'b1;
        for (int i = 0; i < 4; i++) if (rq_head[i] < rq_tail[i]) e = 1'b0;
        return e;
    endfunction

    // Called at a negedge. Runs requesters until the selected stop condition or the cycle budget.
    task automatic pump(input int max_cycles, input int acc_target, input int fall_target,
                        input int exp_gid);
        logic [3:0] hs;
        bit         done = 1'b0;
        for (int k = 0; k < max_cycles && !done; k++) begin
            if (acc_target > 0)       done = (n_acc >= acc_target);
            else if (fall_target > 0) done = (n_fall >= fall_target);
            else                      done = queues_empty() && !grant_valid && !tx_busy;
            if (!done) begin
                if (exp_gid >= 0 && grant_valid) check("gid_held", 32'(grant_id), exp_gid);
                hs = req_valid & req_ready;
                @(posedge clk);
                #1;
                for (int i = 0; i < 4; i++) if (hs[i]) rq_head[i]++;
                drive();
                @(negedge clk);
            end
        end
        check("pump_done", 32'(done), 1);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        clear_queues();
        drive();
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    int         ba, bf, bp, fc;
    logic [3:0] hs0;

    initial begin
        rst = 1'b1;
        req_valid = '0;
        req_last = '0;
        req_data = '0;
        clear_queues();
        drive();
        repeat (2) @(negedge clk);
        check("rst_grant_valid", 32'(grant_valid), 0);
        check("rst_grant_id", 32'(grant_id), 0);
        check("rst_tx_start", 32'(tx_start), 0);
        check("rst_tx_data", 32'(tx_data), 0);
        check("rst_timeout_err", 32'(timeout_err), 0);
        check("rst_req_ready", 32'(req_ready), 0);
        rst = 1'b0;

        // Idle: nothing happens without requests.
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            check("idle_tx_start", 32'(tx_start), 0);
            check("idle_grant_valid", 32'(grant_valid), 0);
            check("idle_req_ready", 32'(req_ready), 0);
        end

        // Single requester, three-byte packet.
        ba = n_acc;
        bf = n_fall;
        push(1, 8'h41, 1'b0);
        push(1, 8'h42, 1'b0);
        push(1, 8'h43, 1'b1);
        drive();
        @(negedge clk);
        check("lat_grant_valid", 32'(grant_valid), 1);
        check("lat_grant_id", 32'(grant_id), 1);
        check("lat_req_ready", 32'(req_ready), 32'h2);
        check("lat_no_start_yet", 32'(tx_start), 0);
        hs0 = req_valid & req_ready;
        @(posedge clk);
        #1;
        for (int i = 0; i < 4; i++) if (hs0[i]) rq_head[i]++;
        drive();
        @(negedge clk);
        check("lat_tx_start", 32'(tx_start), 1);
        check("lat_tx_data", 32'(tx_data), 32'h41);
        check("lat_ready_low", 32'(req_ready), 0);
        pump(400, 0, 0, 1);
        check("single_count", n_acc - ba, 3);
        check("single_b0", 32'(acc_data[ba % 64]), 32'h41);
        check("single_b1", 32'(acc_data[(ba + 1) % 64]), 32'h42);
        check("single_b2", 32'(acc_data[(ba + 2) % 64]), 32'h43);
        check("single_gap1", acc_cyc[(ba + 1) % 64] - fall_cyc[bf % 64], 2);
        check("single_gap2", acc_cyc[(ba + 2) % 64] - fall_cyc[(bf + 1) % 64], 2);
        check("single_released", 32'(grant_valid), 0);

        // ptr is now 2: req3 beats req0.
        ba = n_acc;
        push(0, 8'h01, 1'b1);
        push(3, 8'h03, 1'b1);
        drive();
        @(negedge clk);
        check("ptr2_grant_id", 32'(grant_id), 3);
        pump(400, 0, 0, -1);
        check("ptr2_first", 32'(acc_data[ba % 64]), 32'h03);
        check("ptr2_second", 32'(acc_data[(ba + 1) % 64]), 32'h01);

        // Contention from ptr=0, packets must not interleave.
        do_reset();
        ba = n_acc;
        push(0, 8'h10, 1'b0);
        push(0, 8'h11, 1'b1);
        push(2, 8'h20, 1'b0);
        push(2, 8'h21, 1'b1);
        drive();
        pump(600, 0, 0, -1);
        check("cont_b0", 32'(acc_data[ba % 64]), 32'h10);
        check("cont_b1", 32'(acc_data[(ba + 1) % 64]), 32'h11);
        check("cont_b2", 32'(acc_data[(ba + 2) % 64]), 32'h20);
        check("cont_b3", 32'(acc_data[(ba + 3) % 64]), 32'h21);
        ba = n_acc;
        push(0, 8'h1A, 1'b1);
        push(3, 8'h3A, 1'b1);
        drive();
        @(negedge clk);
        check("cont_rr_grant_id", 32'(grant_id), 3);
        pump(400, 0, 0, -1);
        check("cont_rr_first", 32'(acc_data[ba % 64]), 32'h3A);
        check("cont_rr_second", 32'(acc_data[(ba + 1) % 64]), 32'h1A);

        // Lost start: model drops the first pulse.
        ba = n_acc;
        bp = n_pulse;
        drop_req++;
        push(0, 8'h77, 1'b1);
        drive();
        pump(400, 0, 0, 0);
        check("lost_pulses", n_pulse - bp, 2);
        check("lost_retry_gap", pulse_cyc[(bp + 1) % 64] - pulse_cyc[bp % 64], 5);
        check("lost_data0", 32'(pulse_data[bp % 64]), 32'h77);
        check("lost_data1", 32'(pulse_data[(bp + 1) % 64]), 32'h77);
        check("lost_bytes", n_acc - ba, 1);
        check("lost_byte_val", 32'(acc_data[ba % 64]), 32'h77);

        // Reset during WAIT_LO of byte 2 of a 3-byte packet.
        ba = n_acc;
        push(3, 8'h31, 1'b0);
        push(3, 8'h32, 1'b0);
        push(3, 8'h33, 1'b1);
        drive();
        pump(400, ba + 2, 0, 3);
        @(negedge clk);
        check("mid_owner", 32'(grant_id), 3);
        check("mid_tx_data", 32'(tx_data), 32'h32);
        bp = n_pulse;
        rst = 1'b1;
        #1;
        check("mid_rst_grant_valid", 32'(grant_valid), 0);
        check("mid_rst_grant_id", 32'(grant_id), 0);
        check("mid_rst_tx_start", 32'(tx_start), 0);
        check("mid_rst_tx_data", 32'(tx_data), 0);
        check("mid_rst_timeout_err", 32'(timeout_err), 0);
        check("mid_rst_req_ready", 32'(req_ready), 0);
        clear_queues();
        drive();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (30) @(negedge clk);
        check("mid_no_pulse", n_pulse - bp, 0);
        check("mid_no_grant", 32'(grant_valid), 0);
        ba = n_acc;
        push(0, 8'hA0, 1'b1);
        push(3, 8'hA3, 1'b1);
        drive();
        @(negedge clk);
        check("mid_fresh_grant_id", 32'(grant_id), 0);
        pump(400, 0, 0, -1);
        check("mid_fresh_first", 32'(acc_data[ba % 64]), 32'hA0);
        check("mid_fresh_second", 32'(acc_data[(ba + 1) % 64]), 32'hA3);

        // Timeout: req1 sends a non-final byte then goes silent.
        ba = n_acc;
        bf = n_fall;
        push(1, 8'h55, 1'b0);
        drive();
        pump(400, 0, bf + 1, 1);
        fc = fall_cyc[(n_fall - 1) % 64];
        check("to_byte", 32'(acc_data[ba % 64]), 32'h55);
        push(2, 8'h66, 1'b1);
        drive();
        for (int k = 0; k < 200 && !timeout_err; k++) @(negedge clk);
        check("to_seen", 32'(timeout_err), 1);
        check("to_cycle", cyc - fc, 51);
        check("to_grant_dropped", 32'(grant_valid), 0);
        @(negedge clk);
        check("to_one_pulse", 32'(timeout_err), 0);
        check("to_next_grant", 32'(grant_valid), 1);
        check("to_next_id", 32'(grant_id), 2);
        ba = n_acc;
        pump(400, 0, 0, 2);
        check("to_next_byte", 32'(acc_data[ba % 64]), 32'h66);

        check("no_start_while_busy", n_early, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
